scc_run_ctrl: RTL and testbench

Run controller for the SCC core. It holds the core in reset and then enables its clock. It counts execution cycles and stops the core on halt, error or timeout. After the stop it walks a window of data memory through a read port and streams each address/value pair out on a valid/ready interface. It sits between the system (or bench) harness and `scc_f25_top`, replacing ad-hoc reset/clk_en/dump sequencing.

---
 rtl/scc_run_ctrl_if.sv | 31 +++
 rtl/scc_run_ctrl.sv | 165 ++++++++++++++++
 tb/tb_scc_run_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/scc_run_ctrl_if.sv
// Memory read port and dump stream shared between the run controller
// (master) and the data memory / dump consumer (slave).
interface scc_run_ctrl_if;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rd_data;
  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_addr;
  logic [31:0] dump_data;

  modport master (
    output mem_rd_en,
    output mem_addr,
    input  mem_rd_data,
    output dump_valid,
    input  dump_ready,
    output dump_addr,
    output dump_data
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    output mem_rd_data,
    input  dump_valid,
    output dump_ready,
    input  dump_addr,
    input  dump_data
  );
endinterface

// File: rtl/scc_run_ctrl.sv
// Run controller for the SCC core: holds the core in reset, enables its
// clock, counts run cycles, stops on halt/timeout (optionally error), then
// reads a window of data memory and streams address/value pairs out.
// Optional feature macro: SCC_RUN_CTRL_ERR_STOP_EN (nonzero err_bits ends
// the run like a halt). All outputs are registered.
module scc_run_ctrl #(
  parameter int unsigned RST_CYCLES = 3,
  parameter int unsigned TIMEOUT    = 100000,
  parameter logic [31:0] DUMP_BASE  = 32'h0000_0400,
  parameter int unsigned DUMP_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        core_rst,
  output logic        core_clk_en,
  input  logic        halt_f,
  input  logic [1:0]  err_bits,
  output logic        busy,
  output logic        done,
  output logic        timeout_f,
  output logic [1:0]  err_latched,
  output logic [31:0] cycle_count,
  scc_run_ctrl_if.master bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RESET     = 3'd1;
  localparam logic [2:0] S_RUN       = 3'd2;
  localparam logic [2:0] S_DUMP_RD   = 3'd3;
  localparam logic [2:0] S_DUMP_WAIT = 3'd4;
  localparam logic [2:0] S_DUMP_OUT  = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  logic [2:0]  state_reg, state_next;
  logic [31:0] rst_cnt_reg, rst_cnt_next;
  logic [31:0] idx_reg, idx_next;
  logic [31:0] cycle_count_reg, cycle_count_next;
  logic        timeout_reg, timeout_next;
  logic [1:0]  err_reg, err_next;
  logic [31:0] cnt_inc;
  logic        err_stop;

  logic        core_rst_reg, core_clk_en_reg, busy_reg, done_reg;
  logic        mem_rd_en_reg, dump_valid_reg;
  logic [31:0] mem_addr_reg, dump_addr_reg, dump_data_reg;

`ifdef SCC_RUN_CTRL_ERR_STOP_EN
  assign err_stop = |err_bits;
`else
  assign err_stop = 1'b0;
`endif

  // Saturating post-increment of the run-cycle counter
  assign cnt_inc = (cycle_count_reg == 32'hFFFF_FFFF) ? cycle_count_reg
                                                      : cycle_count_reg + 32'd1;

  // Next-state and bookkeeping for the run/dump sequence
  always_comb begin
    state_next       = state_reg;
    rst_cnt_next     = rst_cnt_reg;
    idx_next         = idx_reg;
    cycle_count_next = cycle_count_reg;
    timeout_next     = timeout_reg;
    err_next         = err_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next       = S_RESET;
          rst_cnt_next     = 32'd0;
          idx_next         = 32'd0;
          cycle_count_next = 32'd0;
          timeout_next     = 1'b0;
          err_next         = 2'b00;
        end
      end
      S_RESET: begin
        if (rst_cnt_reg == 32'(RST_CYCLES - 1)) begin
          state_next = S_RUN;
        end else begin
          rst_cnt_next = rst_cnt_reg + 32'd1;
        end
      end
      S_RUN: begin
        cycle_count_next = cnt_inc;
        err_next         = err_reg | err_bits;
        // Halt beats error, error beats timeout
        if (halt_f || err_stop) begin
          state_next = S_DUMP_RD;
        end else if (cnt_inc == 32'(TIMEOUT)) begin
          timeout_next = 1'b1;
          state_next   = S_DUMP_RD;
        end
      end
      S_DUMP_RD:   state_next = S_DUMP_WAIT;
      S_DUMP_WAIT: state_next = S_DUMP_OUT;
      S_DUMP_OUT: begin
        if (bus.dump_ready) begin
          if (idx_reg == 32'(DUMP_WORDS - 1)) begin
            state_next = S_DONE;
          end else begin
            idx_next   = idx_reg + 32'd1;
            state_next = S_DUMP_RD;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, counters and registered outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      rst_cnt_reg     <= 32'd0;
      idx_reg         <= 32'd0;
      cycle_count_reg <= 32'd0;
      timeout_reg     <= 1'b0;
      err_reg         <= 2'b00;
      core_rst_reg    <= 1'b0;
      core_clk_en_reg <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      mem_rd_en_reg   <= 1'b0;
      mem_addr_reg    <= 32'd0;
      dump_valid_reg  <= 1'b0;
      dump_addr_reg   <= 32'd0;
      dump_data_reg   <= 32'd0;
    end else begin
      state_reg       <= state_next;
      rst_cnt_reg     <= rst_cnt_next;
      idx_reg         <= idx_next;
      cycle_count_reg <= cycle_count_next;
      timeout_reg     <= timeout_next;
      err_reg         <= err_next;
      core_rst_reg    <= (state_next == S_RESET);
      core_clk_en_reg <= (state_next == S_RUN);
      busy_reg        <= (state_next != S_IDLE) && (state_next != S_DONE);
      done_reg        <= (state_next == S_DONE);
      mem_rd_en_reg   <= (state_next == S_DUMP_RD);
      mem_addr_reg    <= (state_next == S_DUMP_RD) ? DUMP_BASE + {idx_next[29:0], 2'b00}
                                                   : 32'd0;
      dump_valid_reg  <= (state_next == S_DUMP_OUT);
      // Read data returns the cycle after the strobe, i.e. during DUMP_WAIT
      if (state_reg == S_DUMP_WAIT) begin
        dump_data_reg <= bus.mem_rd_data;
        dump_addr_reg <= DUMP_BASE + {idx_reg[29:0], 2'b00};
      end
    end
  end

  assign core_rst       = core_rst_reg;
  assign core_clk_en    = core_clk_en_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign timeout_f      = timeout_reg;
  assign err_latched    = err_reg;
  assign cycle_count    = cycle_count_reg;
  assign bus.mem_rd_en  = mem_rd_en_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.dump_valid = dump_valid_reg;
  assign bus.dump_addr  = dump_addr_reg;
  assign bus.dump_data  = dump_data_reg;

endmodule

// File: tb/tb_scc_run_ctrl.sv
// Directed testbench for scc_run_ctrl: normal halt, backpressure, timeout,
// halt+timeout, error stop (both builds of SCC_RUN_CTRL_ERR_STOP_EN),
// reset mid-dump and restart.
module tb_scc_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        halt_f;
  logic [1:0]  err_bits;
  logic        core_rst, core_clk_en, busy, done, timeout_f;
  logic [1:0]  err_latched;
  logic [31:0] cycle_count;

  int n_checks = 0;
  int n_errors = 0;

  scc_run_ctrl_if bus ();

  scc_run_ctrl #(
    .RST_CYCLES (3),
    .TIMEOUT    (100),
    .DUMP_BASE  (32'h0000_0400),
    .DUMP_WORDS (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .core_rst    (core_rst),
    .core_clk_en (core_clk_en),
    .halt_f      (halt_f),
    .err_bits    (err_bits),
    .busy        (busy),
    .done        (done),
    .timeout_f   (timeout_f),
    .err_latched (err_latched),
    .cycle_count (cycle_count),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0400: return 32'h1111_1111;
      32'h0000_0404: return 32'h0000_0040;
      32'h0000_0408: return 32'h0000_0039;
      32'h0000_040C: return 32'h2222_2222;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Data memory: one-cycle read latency
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem_word(bus.mem_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulse start and check the reset window; returns in RUN cycle 1
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_c1", {31'd0, core_rst}, 32'd1);
    chk("clken_c1", {31'd0, core_clk_en}, 32'd0);
    chk("busy_c1", {31'd0, busy}, 32'd1);
    chk("cnt_clr", cycle_count, 32'd0);
    chk("tmo_clr", {31'd0, timeout_f}, 32'd0);
    chk("err_clr", {30'd0, err_latched}, 32'd0);
    tick();
    chk("rst_c2", {31'd0, core_rst}, 32'd1);
    tick();
    chk("rst_c3", {31'd0, core_rst}, 32'd1);
    chk("clken_c3", {31'd0, core_clk_en}, 32'd0);
    tick();
    chk("rst_run", {31'd0, core_rst}, 32'd0);
    chk("clken_run", {31'd0, core_clk_en}, 32'd1);
  endtask

  // Advance from RUN cycle cur to RUN cycle n, optionally halting there
  task automatic run_to(input int cur, input int n, input bit do_halt);
    repeat (n - cur) tick();
    chk("clken_hold", {31'd0, core_clk_en}, 32'd1);
    if (do_halt) begin
      halt_f = 1'b1;
      tick();
      halt_f = 1'b0;
    end
  endtask

  // Walk all four dump words starting in DUMP_RD of word 0
  task automatic dump_all(input int stall_word, input int stall_cycles);
    for (int w = 0; w < 4; w++) begin
      logic [31:0] a;
      a = 32'h0000_0400 + 32'(4 * w);
      chk("rd_en", {31'd0, bus.mem_rd_en}, 32'd1);
      chk("rd_addr", bus.mem_addr, a);
      chk("clken_dump", {31'd0, core_clk_en}, 32'd0);
      tick();
      chk("wait_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
      chk("wait_addr0", bus.mem_addr, 32'd0);
      chk("wait_valid", {31'd0, bus.dump_valid}, 32'd0);
      if (w == stall_word) bus.dump_ready = 1'b0;
      tick();
      chk("out_valid", {31'd0, bus.dump_valid}, 32'd1);
      chk("out_addr", bus.dump_addr, a);
      chk("out_data", bus.dump_data, mem_word(a));
      $display("dump word %0d addr=%h data=%h", w, bus.dump_addr, bus.dump_data);
      if (w == stall_word) begin
        for (int s = 1; s < stall_cycles; s++) begin
          tick();
          chk("bp_valid", {31'd0, bus.dump_valid}, 32'd1);
          chk("bp_addr", bus.dump_addr, a);
          chk("bp_data", bus.dump_data, mem_word(a));
          chk("bp_no_rd", {31'd0, bus.mem_rd_en}, 32'd0);
        end
        bus.dump_ready = 1'b1;
      end
      tick();
    end
    chk("done", {31'd0, done}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("done_valid", {31'd0, bus.dump_valid}, 32'd0);
    chk("done_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_core_rst"}, {31'd0, core_rst}, 32'd0);
    chk({tag, "_clk_en"}, {31'd0, core_clk_en}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_tmo"}, {31'd0, timeout_f}, 32'd0);
    chk({tag, "_err"}, {30'd0, err_latched}, 32'd0);
    chk({tag, "_cnt"}, cycle_count, 32'd0);
    chk({tag, "_rd_en"}, {31'd0, bus.mem_rd_en}, 32'd0);
    chk({tag, "_addr"}, bus.mem_addr, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.dump_valid}, 32'd0);
    chk({tag, "_daddr"}, bus.dump_addr, 32'd0);
    chk({tag, "_ddata"}, bus.dump_data, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    halt_f = 1'b0;
    err_bits = 2'b00;
    bus.dump_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_all_zero("por");
    tick();

    // Normal halt in RUN cycle 40
    do_start();
    run_to(1, 40, 1'b1);
    chk("halt_cnt", cycle_count, 32'd40);
    chk("halt_tmo", {31'd0, timeout_f}, 32'd0);
    dump_all(-1, 0);
    chk("halt_cnt_done", cycle_count, 32'd40);

    // Backpressure on word 1 for 5 cycles
    do_start();
    run_to(1, 5, 1'b1);
    chk("bp_cnt", cycle_count, 32'd5);
    dump_all(1, 5);

    // Timeout after 100 RUN cycles
    do_start();
    run_to(1, 100, 1'b0);
    tick();
    chk("tmo_clk_en", {31'd0, core_clk_en}, 32'd0);
    chk("tmo_cnt", cycle_count, 32'd100);
    chk("tmo_flag", {31'd0, timeout_f}, 32'd1);
    dump_all(-1, 0);
    chk("tmo_flag_done", {31'd0, timeout_f}, 32'd1);

    // Halt and timeout in the same cycle: halt wins
    do_start();
    run_to(1, 100, 1'b1);
    chk("ht_cnt", cycle_count, 32'd100);
    chk("ht_tmo", {31'd0, timeout_f}, 32'd0);
    dump_all(-1, 0);

    // Error bits in RUN cycle 7
    do_start();
    run_to(1, 7, 1'b0);
    err_bits = 2'b10;
    tick();
    err_bits = 2'b00;
    chk("err_latched", {30'd0, err_latched}, 32'd2);
    chk("err_cnt", cycle_count, 32'd7);
`ifdef SCC_RUN_CTRL_ERR_STOP_EN
    chk("err_stop_tmo", {31'd0, timeout_f}, 32'd0);
    dump_all(-1, 0);
`else
    chk("err_no_stop", {31'd0, core_clk_en}, 32'd1);
    run_to(8, 20, 1'b1);
    chk("err_run_cnt", cycle_count, 32'd20);
    dump_all(-1, 0);
`endif
    chk("err_done", {30'd0, err_latched}, 32'd2);

    // Reset while dump_valid is high, then a fresh sequence
    do_start();
    run_to(1, 3, 1'b1);
    tick();
    tick();
    chk("mid_valid", {31'd0, bus.dump_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("mid_rst");
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    do_start();
    run_to(1, 10, 1'b1);
    chk("fresh_cnt", cycle_count, 32'd10);
    chk("fresh_err", {30'd0, err_latched}, 32'd0);
    dump_all(-1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
